// File: rtl/vga_pkg.sv
// Shared video timing constants for the XGA 1024x768@60 pipeline.
// Draw stages import this for edge tests (last visible column/line, etc.).
package vga_pkg;

  // Width of hcount/vcount on the timing bus
  localparam int CNT_W = 12;

  // XGA 1024x768 @ 60 Hz, 65 MHz pixel clock
  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;

  // Derived totals
  localparam int XGA_H_TOTAL = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
  localparam int XGA_V_TOTAL = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  // Sync windows: start inclusive, end exclusive
  localparam int XGA_HS_START = XGA_H_ACTIVE + XGA_H_FP;
  localparam int XGA_HS_END   = XGA_HS_START + XGA_H_SYNC;
  localparam int XGA_VS_START = XGA_V_ACTIVE + XGA_V_FP;
  localparam int XGA_VS_END   = XGA_VS_START + XGA_V_SYNC;

  // Last visible column / line, handy for draw-stage edge tests
  localparam int XGA_H_LAST_VIS = XGA_H_ACTIVE - 1;
  localparam int XGA_V_LAST_VIS = XGA_V_ACTIVE - 1;

  // True when lo <= c < hi
  function automatic logic in_window(input logic [CNT_W-1:0] c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Head of the video pipeline: free-running hcount/vcount with coherent
// sync/blank/frame_start flags. Next position and its flags are computed
// combinationally and registered together, so counts and flags never skew.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic             pclk,
  input  logic             reset,
  output logic [CNT_W-1:0] hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic             frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] w_hcount_nx;
  logic [CNT_W-1:0] w_vcount_nx;
  logic             w_hsync_nx;
  logic             w_hblnk_nx;
  logic             w_vsync_nx;
  logic             w_vblnk_nx;
  logic             w_frame_nx;

  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic             r_hsync;
  logic             r_hblnk;
  logic             r_vsync;
  logic             r_vblnk;
  logic             r_frame;

  // Next raster position; reset forces the origin so its flags decode from (0,0).
  // Wrap on >= so an out-of-range count can never persist.
  always_comb begin
    w_hcount_nx = r_hcount + ONE;
    w_vcount_nx = r_vcount;
    if (reset) begin
      w_hcount_nx = '0;
      w_vcount_nx = '0;
    end else if (r_hcount >= H_LAST) begin
      w_hcount_nx = '0;
      if (r_vcount >= V_LAST) begin
        w_vcount_nx = '0;
      end else begin
        w_vcount_nx = r_vcount + ONE;
      end
    end
  end

  // Flags decoded from the next position so they land on the same edge as the counts.
  // vsync depends only on vcount, so its edges fall at hcount==0.
  always_comb begin
    w_hblnk_nx = (w_hcount_nx >= H_ACT);
    w_vblnk_nx = (w_vcount_nx >= V_ACT);
    w_hsync_nx = in_window(w_hcount_nx, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    w_vsync_nx = in_window(w_vcount_nx, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    w_frame_nx = (w_hcount_nx == '0) && (w_vcount_nx == '0);
  end

  // Register counts and flags together.
  always_ff @(posedge pclk) begin
    r_hcount <= w_hcount_nx;
    r_vcount <= w_vcount_nx;
    r_hsync  <= w_hsync_nx;
    r_hblnk  <= w_hblnk_nx;
    r_vsync  <= w_vsync_nx;
    r_vblnk  <= w_vblnk_nx;
    r_frame  <= w_frame_nx;
  end

  assign hcount_out  = r_hcount;
  assign vcount_out  = r_vcount;
  assign hsync_out   = r_hsync;
  assign hblnk_out   = r_hblnk;
  assign vsync_out   = r_vsync;
  assign vblnk_out   = r_vblnk;
  assign frame_start = r_frame;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: one XGA instance plus two reduced-timing
// instances (active-high and active-low sync) for the vertical and frame checks.
// Reduced timing: H 16/2/3/4 (total 25), V 8/1/2/3 (total 14), frame 350.
module tb_vga_timing;

  logic pclk  = 1'b0;
  logic reset = 1'b1;

  always #5 pclk = ~pclk;

  logic [11:0] d_h, d_v, s_h, s_v, n_h, n_v;
  logic d_hs, d_hb, d_vs, d_vb, d_fs;
  logic s_hs, s_hb, s_vs, s_vb, s_fs;
  logic n_hs, n_hb, n_vs, n_vb, n_fs;

  vga_timing dut (
    .pclk(pclk), .reset(reset),
    .hcount_out(d_h), .hsync_out(d_hs), .hblnk_out(d_hb),
    .vcount_out(d_v), .vsync_out(d_vs), .vblnk_out(d_vb),
    .frame_start(d_fs)
  );

  vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) dut_s (
    .pclk(pclk), .reset(reset),
    .hcount_out(s_h), .hsync_out(s_hs), .hblnk_out(s_hb),
    .vcount_out(s_v), .vsync_out(s_vs), .vblnk_out(s_vb),
    .frame_start(s_fs)
  );

  vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) dut_n (
    .pclk(pclk), .reset(reset),
    .hcount_out(n_h), .hsync_out(n_hs), .hblnk_out(n_hb),
    .vcount_out(n_v), .vsync_out(n_vs), .vblnk_out(n_vb),
    .frame_start(n_fs)
  );

  // Packed views: {hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start}
  logic [28:0] d_obs, s_obs, n_obs;
  assign d_obs = {d_h, d_v, d_hb, d_vb, d_hs, d_vs, d_fs};
  assign s_obs = {s_h, s_v, s_hb, s_vb, s_hs, s_vs, s_fs};
  assign n_obs = {n_h, n_v, n_hb, n_vb, n_hs, n_vs, n_fs};

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;   // cycles since the origin was last presented

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge pclk);
      cyc++;
    end
  endtask

  task automatic goto(input int t);
    vectors++;
    if (t < cyc) begin
      miscompares++;
      $display("FAIL goto: at cycle %0d, cannot reach %0d", cyc, t);
    end else begin
      tick(t - cyc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge pclk);
    cyc = 0;
    vectors++;
    if (d_obs !== {12'd0, 12'd0, 5'b00001}) begin
      miscompares++; $display("FAIL reset_xga: got %h expected %h", d_obs, {12'd0, 12'd0, 5'b00001});
    end
    vectors++;
    if (n_obs !== {12'd0, 12'd0, 5'b00111}) begin
      miscompares++; $display("FAIL reset_negpol: got %h expected %h", n_obs, {12'd0, 12'd0, 5'b00111});
    end
    reset = 1'b0;
    tick(1);
    vectors++;
    if (d_obs !== {12'd1, 12'd0, 5'b00000}) begin
      miscompares++; $display("FAIL reset_release: got %h expected %h", d_obs, {12'd1, 12'd0, 5'b00000});
    end
  endtask

  task automatic test_hsync_window;
    goto(1023);
    vectors++;
    if (d_obs !== {12'd1023, 12'd0, 5'b00000}) begin
      miscompares++; $display("FAIL h1023: got %h expected %h", d_obs, {12'd1023, 12'd0, 5'b00000});
    end
    goto(1024);
    vectors++;
    if (d_obs !== {12'd1024, 12'd0, 5'b10000}) begin
      miscompares++; $display("FAIL hblnk_rise: got %h expected %h", d_obs, {12'd1024, 12'd0, 5'b10000});
    end
    goto(1047);
    vectors++;
    if (d_obs !== {12'd1047, 12'd0, 5'b10000}) begin
      miscompares++; $display("FAIL h1047: got %h expected %h", d_obs, {12'd1047, 12'd0, 5'b10000});
    end
    for (int i = 1048; i <= 1183; i++) begin
      goto(i);
      vectors++;
      if (d_obs !== {12'(i), 12'd0, 5'b10100}) begin
        miscompares++; $display("FAIL hsync_on: got %h expected %h", d_obs, {12'(i), 12'd0, 5'b10100});
      end
    end
    goto(1184);
    vectors++;
    if (d_obs !== {12'd1184, 12'd0, 5'b10000}) begin
      miscompares++; $display("FAIL hsync_off: got %h expected %h", d_obs, {12'd1184, 12'd0, 5'b10000});
    end
  endtask

  task automatic test_line_wrap;
    goto(5 * 1344 + 1343);
    vectors++;
    if (d_obs !== {12'd1343, 12'd5, 5'b10000}) begin
      miscompares++; $display("FAIL line_end: got %h expected %h", d_obs, {12'd1343, 12'd5, 5'b10000});
    end
    goto(6 * 1344);
    vectors++;
    if (d_obs !== {12'd0, 12'd6, 5'b00000}) begin
      miscompares++; $display("FAIL line_wrap: got %h expected %h", d_obs, {12'd0, 12'd6, 5'b00000});
    end
  endtask

  task automatic test_reset_mid;
    goto(7 * 1344 + 500);
    vectors++;
    if (d_obs !== {12'd500, 12'd7, 5'b00000}) begin
      miscompares++; $display("FAIL mid_pos: got %h expected %h", d_obs, {12'd500, 12'd7, 5'b00000});
    end
    reset = 1'b1;
    @(negedge pclk);
    cyc = 0;
    vectors++;
    if (d_obs !== {12'd0, 12'd0, 5'b00001}) begin
      miscompares++; $display("FAIL mid_reset_xga: got %h expected %h", d_obs, {12'd0, 12'd0, 5'b00001});
    end
    vectors++;
    if (s_obs !== {12'd0, 12'd0, 5'b00001}) begin
      miscompares++; $display("FAIL mid_reset_small: got %h expected %h", s_obs, {12'd0, 12'd0, 5'b00001});
    end
    reset = 1'b0;
    tick(1);
    vectors++;
    if (d_obs !== {12'd1, 12'd0, 5'b00000}) begin
      miscompares++; $display("FAIL mid_resume: got %h expected %h", d_obs, {12'd1, 12'd0, 5'b00000});
    end
    goto(1344);
    vectors++;
    if (d_obs !== {12'd0, 12'd1, 5'b00000}) begin
      miscompares++; $display("FAIL mid_line1: got %h expected %h", d_obs, {12'd0, 12'd1, 5'b00000});
    end
  endtask

  task automatic test_polarity;
    reset = 1'b1;
    @(negedge pclk);
    reset = 1'b0;
    cyc = 0;
    goto(15);
    vectors++;
    if ({s_obs, n_obs} !== {12'd15, 12'd0, 5'b00000, 12'd15, 12'd0, 5'b00110}) begin
      miscompares++; $display("FAIL pol_h15: got %h/%h", s_obs, n_obs);
    end
    goto(16);
    vectors++;
    if ({s_obs, n_obs} !== {12'd16, 12'd0, 5'b10000, 12'd16, 12'd0, 5'b10110}) begin
      miscompares++; $display("FAIL pol_h16: got %h/%h", s_obs, n_obs);
    end
    goto(17);
    vectors++;
    if ({s_obs, n_obs} !== {12'd17, 12'd0, 5'b10000, 12'd17, 12'd0, 5'b10110}) begin
      miscompares++; $display("FAIL pol_h17: got %h/%h", s_obs, n_obs);
    end
    goto(18);
    vectors++;
    if ({s_obs, n_obs} !== {12'd18, 12'd0, 5'b10100, 12'd18, 12'd0, 5'b10010}) begin
      miscompares++; $display("FAIL pol_h18: got %h/%h", s_obs, n_obs);
    end
    goto(20);
    vectors++;
    if ({s_obs, n_obs} !== {12'd20, 12'd0, 5'b10100, 12'd20, 12'd0, 5'b10010}) begin
      miscompares++; $display("FAIL pol_h20: got %h/%h", s_obs, n_obs);
    end
    goto(21);
    vectors++;
    if ({s_obs, n_obs} !== {12'd21, 12'd0, 5'b10000, 12'd21, 12'd0, 5'b10110}) begin
      miscompares++; $display("FAIL pol_h21: got %h/%h", s_obs, n_obs);
    end
  endtask

  task automatic test_vertical;
    goto(199);
    vectors++;
    if ({s_obs, n_obs} !== {12'd24, 12'd7, 5'b10000, 12'd24, 12'd7, 5'b10110}) begin
      miscompares++; $display("FAIL v7_end: got %h/%h", s_obs, n_obs);
    end
    goto(200);
    vectors++;
    if ({s_obs, n_obs} !== {12'd0, 12'd8, 5'b01000, 12'd0, 12'd8, 5'b01110}) begin
      miscompares++; $display("FAIL vblnk_rise: got %h/%h", s_obs, n_obs);
    end
    goto(224);
    vectors++;
    if ({s_obs, n_obs} !== {12'd24, 12'd8, 5'b11000, 12'd24, 12'd8, 5'b11110}) begin
      miscompares++; $display("FAIL v8_end: got %h/%h", s_obs, n_obs);
    end
    goto(225);
    vectors++;
    if ({s_obs, n_obs} !== {12'd0, 12'd9, 5'b01010, 12'd0, 12'd9, 5'b01100}) begin
      miscompares++; $display("FAIL vsync_rise: got %h/%h", s_obs, n_obs);
    end
    for (int i = 226; i <= 274; i++) begin
      goto(i);
      vectors++;
      if ({s_vs, n_vs, s_vb, n_vb} !== 4'b1011) begin
        miscompares++; $display("FAIL vsync_on: cycle %0d got %b expected 1011", i, {s_vs, n_vs, s_vb, n_vb});
      end
    end
    goto(275);
    vectors++;
    if ({s_obs, n_obs} !== {12'd0, 12'd11, 5'b01000, 12'd0, 12'd11, 5'b01110}) begin
      miscompares++; $display("FAIL vsync_fall: got %h/%h", s_obs, n_obs);
    end
  endtask

  task automatic test_frame_wrap;
    int spacing;
    goto(349);
    vectors++;
    if (s_obs !== {12'd24, 12'd13, 5'b11000}) begin
      miscompares++; $display("FAIL frame_end: got %h expected %h", s_obs, {12'd24, 12'd13, 5'b11000});
    end
    goto(350);
    vectors++;
    if ({s_obs, n_obs} !== {12'd0, 12'd0, 5'b00001, 12'd0, 12'd0, 5'b00111}) begin
      miscompares++; $display("FAIL frame_wrap: got %h/%h", s_obs, n_obs);
    end
    spacing = 0;
    for (int k = 0; k < 400; k++) begin
      tick(1);
      spacing++;
      if (s_fs === 1'b1) break;
    end
    vectors++;
    if (spacing !== 350) begin
      miscompares++; $display("FAIL frame_spacing: got %0d expected 350", spacing);
    end
  endtask

  initial begin
    test_reset();
    test_hsync_window();
    test_line_wrap();
    test_reset_mid();
    test_polarity();
    test_vertical();
    test_frame_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
